// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } ps2_state_e;

   localparam int unsigned FRAME_BITS  = 11;
   localparam int unsigned DATA_BITS   = 8;
   localparam logic [7:0]  BREAK_CODE  = 8'hF0;
   localparam logic [7:0]  EXTEND_CODE = 8'hE0;

   // Parity bit that makes the 9-bit group {d, p} contain an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/ps2_rx_port_if.sv
// Holding-register handshake between the PS/2 receiver and its consumer.
interface ps2_rx_port_if;
   logic       rx_en;
   logic       rd_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       overrun;

   modport master (input rx_en, rd_ack, output data_out, data_valid, parity_err, overrun);
   modport slave  (output rx_en, rd_ack, input data_out, data_valid, parity_err, overrun);
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises a PS/2 clock/data pin pair, debounces the clock and flags its falling edges.
module ps2_clk_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c,
   input  logic ps2d,
   output logic ps2d_s,
   output logic fall_tick
);

   logic [1:0]            c_sync;
   logic [1:0]            d_sync;
   logic [FILTER_LEN-1:0] shreg;
   logic                  filt;

   // Level changes only after FILTER_LEN identical samples; otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_sync    <= '1;
         d_sync    <= '1;
         shreg     <= '1;
         filt      <= 1'b1;
         fall_tick <= 1'b0;
      end else begin
         c_sync    <= {c_sync[0], ps2c};
         d_sync    <= {d_sync[0], ps2d};
         shreg     <= {shreg[FILTER_LEN-2:0], c_sync[1]};
         fall_tick <= filt & ~(|shreg);
         if (&shreg)
            filt <= 1'b1;
         else if (~(|shreg))
            filt <= 1'b0;
      end
   end

   assign ps2d_s = d_sync[1];

endmodule

// File: rtl/ps2_rx_port.sv
// PS/2 keyboard frame receiver with a one-entry holding register.
// Optional PS2_BREAK_FILTER_EN: drop F0 break codes and the key code that follows them.
module ps2_rx_port
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2d,
   input  logic             ps2c,
   ps2_rx_port_if.master    bus
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS);
   localparam int unsigned SR_W  = FRAME_BITS - 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   ps2_state_e        state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SR_W-1:0]   sr;
   logic [TO_W-1:0]   tcnt;
   logic              ps2d_s, fall_tick;
   logic              frame_ok_c, timeout_c;
   logic              start_c, shift_c, load_c, err_c;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .ps2d_s    (ps2d_s),
      .fall_tick (fall_tick)
   );

   // sr holds {stop, parity, data[7:0]} once the frame is complete.
   assign frame_ok_c = (sr[DATA_BITS] == odd_parity(sr[DATA_BITS-1:0])) & sr[SR_W-1];
   assign timeout_c  = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_BREAK_FILTER_EN
   logic break_pending;
   logic brk_set_c, brk_clr_c;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fall_tick && !ps2d_s && bus.rx_en) state_nxt = RECV;
         RECV: begin
            if (fall_tick) begin
               if (bit_cnt == CNT_W'(1)) state_nxt = CHECK;
            end else if (timeout_c) begin
               state_nxt = IDLE;
            end
         end
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_c = 1'b0;
      shift_c = 1'b0;
      load_c  = 1'b0;
      err_c   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_set_c = 1'b0;
      brk_clr_c = 1'b0;
`endif
      case (state)
         IDLE: start_c = fall_tick & ~ps2d_s & bus.rx_en;
         RECV: shift_c = fall_tick;
         CHECK: begin
            if (!frame_ok_c) begin
               err_c = 1'b1;
            end else begin
`ifdef PS2_BREAK_FILTER_EN
               // The byte after a break code is the released key; swallow both.
               if (break_pending)
                  brk_clr_c = 1'b1;
               else if (sr[DATA_BITS-1:0] == BREAK_CODE)
                  brk_set_c = 1'b1;
               else
                  load_c = 1'b1;
`else
               load_c = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   // Frame deserialiser and inter-edge timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         sr      <= '0;
         tcnt    <= '0;
      end else begin
         if (start_c) begin
            bit_cnt <= CNT_W'(FRAME_BITS - 1);
         end else if (shift_c) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            sr      <= {ps2d_s, sr[SR_W-1:1]};
         end
         if (state != RECV || fall_tick)
            tcnt <= '0;
         else if (!timeout_c)
            tcnt <= tcnt + TO_W'(1);
      end
   end

   // Holding register: a load beats a simultaneous acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.parity_err <= err_c;
         if (load_c) begin
            bus.data_out   <= sr[DATA_BITS-1:0];
            bus.data_valid <= 1'b1;
            if (bus.data_valid && !bus.rd_ack)
               bus.overrun <= 1'b1;
            else if (bus.rd_ack)
               bus.overrun <= 1'b0;
         end else if (bus.rd_ack && bus.data_valid) begin
            bus.data_valid <= 1'b0;
            bus.overrun    <= 1'b0;
         end
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          break_pending <= 1'b0;
      else if (brk_set_c) break_pending <= 1'b1;
      else if (brk_clr_c) break_pending <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_ps2_rx_port.sv
// Scoreboard bench for ps2_rx_port: drives PS/2 frames on the pins and checks the holding register.
module tb_ps2_rx_port;
   import ps2_pkg::*;

   localparam int unsigned FILT = 8;
   localparam int unsigned TMO  = 1000;

   logic clk = 1'b0;
   logic reset;
   logic ps2c, ps2d;
   ps2_rx_port_if bus();

   ps2_rx_port #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .ps2d  (ps2d),
      .ps2c  (ps2c),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int perr_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp;
   bit brk = 1'b0;

   always @(negedge clk) if (bus.parity_err === 1'b1) perr_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      @(negedge clk) bus.rd_ack = 1'b1;
      @(negedge clk) bus.rd_ack = 1'b0;
   endtask

   // Reference model of which good bytes should reach the holding register.
   function automatic void model_push(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
      if (brk) brk = 1'b0;
      else if (b == 8'hF0) brk = 1'b1;
      else exp_q.push_back(b);
`else
      exp_q.push_back(b);
`endif
   endfunction

   task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_at,
                            input bit watch_stop, input logic [7:0] b);
      int k;
      for (int i = 0; i < nbits; i++) begin
         ps2d = f[i];
         wait_cycles(20);
         ps2c = 1'b0;
         if (watch_stop && i == 10) begin
            k = 0;
            while (k < 30 && dut.u_filter.fall_tick !== 1'b1) begin
               @(negedge clk);
               k++;
            end
            checks++;
            if (dut.u_filter.fall_tick !== 1'b1) begin
               errors++;
               $display("FAIL stop_fall_tick: got %b required 1", dut.u_filter.fall_tick);
            end else begin
               checks++;
               if (bus.data_valid !== 1'b0) begin
                  errors++; $display("FAIL lat_tick: data_valid %b required 0", bus.data_valid);
               end
               @(negedge clk);
               checks++;
               if (bus.data_valid !== 1'b0) begin
                  errors++; $display("FAIL lat_edge1: data_valid %b required 0", bus.data_valid);
               end
               @(negedge clk);
               checks++;
               if (bus.data_valid !== 1'b1 || bus.data_out !== b) begin
                  errors++;
                  $display("FAIL lat_edge2: valid %b data %h required 1 %h", bus.data_valid, bus.data_out, b);
               end
            end
            wait_cycles(20);
         end else begin
            wait_cycles(40);
         end
         ps2c = 1'b1;
         wait_cycles(20);
         if (i == glitch_at) begin
            ps2c = 1'b0; wait_cycles(3); ps2c = 1'b1; wait_cycles(20);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_at,
                             input bit watch_stop);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      send_bits(f, 11, glitch_at, watch_stop, b);
      if (!bad_par) model_push(b);
      wait_cycles(5);
   endtask

   task automatic test_reset();
      reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
      bus.rx_en = 1'b1; bus.rd_ack = 1'b0;
      wait_cycles(5);
      checks++;
      if (bus.data_out !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h required 00", bus.data_out);
      end
      checks++;
      if ({bus.data_valid, bus.parity_err, bus.overrun} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b required 000", {bus.data_valid, bus.parity_err, bus.overrun});
      end
      checks++;
      if (dut.state !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d required IDLE", dut.state);
      end
      reset = 1'b0;
      wait_cycles(20);
      pulse_ack();
      checks++;
      if (bus.data_valid !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL idle_ack: valid %b ovr %b required 0 0", bus.data_valid, bus.overrun);
      end
   endtask

   task automatic test_parity();
      int p0;
      p0 = perr_cnt;
      send_frame(8'h1C, 1'b1, -1, 1'b0);
      checks++;
      if (perr_cnt - p0 != 1) begin
         errors++; $display("FAIL parity_pulse: got %0d cycles required 1", perr_cnt - p0);
      end
      checks++;
      if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00 || exp_q.size() != 0) begin
         errors++; $display("FAIL parity_hold: valid %b data %h required 0 00", bus.data_valid, bus.data_out);
      end
   endtask

   task automatic test_basic();
      send_frame(8'h1C, 1'b0, -1, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
         errors++; $display("FAIL basic_rx: valid %b data %h required 1 %h", bus.data_valid, bus.data_out, exp);
      end
      pulse_ack();
      checks++;
      if (bus.data_valid !== 1'b0) begin
         errors++; $display("FAIL basic_ack: valid %b required 0", bus.data_valid);
      end
   endtask

   task automatic test_overrun();
      send_frame(8'h1C, 1'b0, -1, 1'b0);
      send_frame(8'h32, 1'b0, -1, 1'b0);
      checks++;
      if (exp_q.size() != 2) begin
         errors++; $display("FAIL ovr_queue: got %0d required 2", exp_q.size());
      end
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp || bus.data_valid !== 1'b1 || bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set: data %h valid %b ovr %b required %h 1 1", bus.data_out, bus.data_valid, bus.overrun, exp);
      end
      pulse_ack();
      checks++;
      if (bus.data_valid !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL ovr_clear: valid %b ovr %b required 0 0", bus.data_valid, bus.overrun);
      end
   endtask

   task automatic test_timeout();
      int p0;
      logic [10:0] f;
      p0 = perr_cnt;
      f = {1'b1, 1'b0, 8'hA5, 1'b0};
      send_bits(f, 5, -1, 1'b0, 8'h00);
      wait_cycles(TMO + 100);
      checks++;
      if (dut.state !== IDLE || bus.data_valid !== 1'b0 || perr_cnt != p0) begin
         errors++;
         $display("FAIL timeout_idle: state %0d valid %b perr %0d required IDLE 0 0", dut.state, bus.data_valid, perr_cnt - p0);
      end
      send_frame(8'h29, 1'b0, -1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
         errors++; $display("FAIL timeout_next: valid %b data %h required 1 %h", bus.data_valid, bus.data_out, exp);
      end
      pulse_ack();
   endtask

   task automatic test_glitch();
      ps2d = 1'b1;
      ps2c = 1'b0; wait_cycles(3); ps2c = 1'b1;
      wait_cycles(30);
      checks++;
      if (dut.state !== IDLE) begin
         errors++; $display("FAIL glitch_idle: state %0d required IDLE", dut.state);
      end
      send_frame(8'h1C, 1'b0, 3, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
         errors++; $display("FAIL glitch_rx: valid %b data %h required 1 %h", bus.data_valid, bus.data_out, exp);
      end
      pulse_ack();
   endtask

   task automatic test_reset_mid();
      logic [10:0] f;
      send_frame(8'h5A, 1'b0, -1, 1'b0);
      f = {1'b1, 1'b0, 8'h3C, 1'b0};
      send_bits(f, 4, -1, 1'b0, 8'h00);
      reset = 1'b1;
      exp_q.delete();
      brk = 1'b0;
      wait_cycles(3);
      checks++;
      if ({bus.data_out, bus.data_valid, bus.parity_err, bus.overrun} !== 11'h000) begin
         errors++;
         $display("FAIL midreset_out: data %h valid %b perr %b ovr %b required 00 0 0 0",
                  bus.data_out, bus.data_valid, bus.parity_err, bus.overrun);
      end
      reset = 1'b0;
      wait_cycles(30);
      send_frame(8'h1C, 1'b0, -1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
         errors++; $display("FAIL midreset_rx: valid %b data %h required 1 %h", bus.data_valid, bus.data_out, exp);
      end
      pulse_ack();
   endtask

   task automatic test_break();
      logic [7:0] seq[3];
      int n_valid, n_exp;
      seq = '{8'hF0, 8'h1C, 8'h1C};
      n_valid = 0;
`ifdef PS2_BREAK_FILTER_EN
      n_exp = 1;
`else
      n_exp = 3;
`endif
      for (int i = 0; i < 3; i++) begin
         send_frame(seq[i], 1'b0, -1, 1'b0);
         if (bus.data_valid === 1'b1) n_valid++;
         checks++;
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
               errors++; $display("FAIL break_rx%0d: valid %b data %h required 1 %h", i, bus.data_valid, bus.data_out, exp);
            end
         end else if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL break_drop%0d: valid %b required 0", i, bus.data_valid);
         end
         pulse_ack();
      end
      checks++;
      if (n_valid != n_exp) begin
         errors++; $display("FAIL break_count: got %0d required %0d", n_valid, n_exp);
      end
   endtask

   initial begin
      test_reset();
      test_parity();
      test_basic();
      test_overrun();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_break();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
